// File: rtl/mem_fetch_unit.sv
// ---------------------------------------------------------------------------
// mem_fetch_unit
//
// Instruction-fetch and memory stage sitting directly behind the control unit.
// Holds the unified program/data RAM, the program counter, the upper/lower
// instruction registers (IRU/IRL) and the memory data register (MDR). The
// control unit's strobes are executed on every rising edge. A host program
// port can own the RAM (prog_en) to load or inspect contents between runs.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   rst        : synchronous active-high reset (PC/IRU/IRL/MDR, never RAM)
//   load_pc    : PC <- IRL (jump), wins over incr_pc
//   incr_pc    : PC <- PC + 1, wraps modulo 2^ADDR_W
//   load_iru   : IRU <- MDR
//   load_irl   : IRL <- MDR
//   fetch      : address select, 1 = PC, 0 = IRL
//   store_mem  : RAM[IRL] <- ac_in, only when fetch = 0 and host is idle
//   ac_in      : accumulator value for core stores
//   prog_en    : host owns RAM, core strobes ignored, PC/IRU/IRL frozen
//   prog_we    : host write strobe (needs prog_en)
//   prog_addr  : host write/read address
//   prog_data  : host write data
//   opcode     : IRU contents
//   operand    : IRL contents
//   mdr        : registered RAM read data (1-cycle latency, read-first)
//   pc         : current program counter
//   mem_addr   : address presented to RAM this cycle
// ---------------------------------------------------------------------------
module mem_fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_pc,
  input  logic              incr_pc,
  input  logic              load_iru,
  input  logic              load_irl,
  input  logic              fetch,
  input  logic              store_mem,
  input  logic [DATA_W-1:0] ac_in,
  input  logic              prog_en,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] opcode,
  output logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] mdr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] mem_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  // Storage and architectural registers
  logic [DATA_W-1:0] ram_r [DEPTH];
  logic [ADDR_W-1:0] pc_r;
  logic [DATA_W-1:0] iru_r;
  logic [DATA_W-1:0] irl_r;
  logic [DATA_W-1:0] mdr_r;

  // Combinational helpers
  logic [ADDR_W-1:0] irl_addr_s;
  logic [ADDR_W-1:0] addr_s;
  logic [ADDR_W-1:0] pc_next_s;
  logic              host_we_s;
  logic              core_we_s;
  logic              core_en_s;

  // IRL carries a data-width value; only its low ADDR_W bits form an address.
  function automatic logic [ADDR_W-1:0] irl_to_addr(input logic [DATA_W-1:0] v);
    return ADDR_W'(v);
  endfunction

  // Wrapping increment: the carry out of the top bit is simply dropped.
  function automatic logic [ADDR_W-1:0] pc_plus_one(input logic [ADDR_W-1:0] v);
    return v + ADDR_W'(1);
  endfunction

  assign irl_addr_s = irl_to_addr(irl_r);
  assign core_en_s  = ~prog_en;
  assign host_we_s  = prog_en & prog_we;
  // Reset suppresses core stores; host writes still go through during reset.
  assign core_we_s  = store_mem & ~fetch & core_en_s & ~rst;

  // RAM address mux: host first, then PC for instruction fetch, else operand.
  always_comb begin
    addr_s = {ADDR_W{1'b0}};
    if (prog_en) begin
      addr_s = prog_addr;
    end else if (fetch) begin
      addr_s = pc_r;
    end else begin
      addr_s = irl_addr_s;
    end
  end

  // Next PC: jump beats increment, otherwise hold.
  always_comb begin
    pc_next_s = pc_r;
    if (load_pc) begin
      pc_next_s = irl_addr_s;
    end else if (incr_pc) begin
      pc_next_s = pc_plus_one(pc_r);
    end else begin
      pc_next_s = pc_r;
    end
  end

  // RAM write port; RAM is deliberately never reset so programs survive rst.
  always_ff @(posedge clk) begin
    if (host_we_s) begin
      ram_r[prog_addr] <= prog_data;
    end else if (core_we_s) begin
      ram_r[irl_addr_s] <= ac_in;
    end
  end

  // MDR, PC and instruction registers. MDR samples the RAM before this edge's
  // write lands, giving read-first behaviour on a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r  <= {ADDR_W{1'b0}};
      iru_r <= {DATA_W{1'b0}};
      irl_r <= {DATA_W{1'b0}};
      mdr_r <= {DATA_W{1'b0}};
    end else begin
      mdr_r <= ram_r[addr_s];
      if (core_en_s) begin
        pc_r <= pc_next_s;
        // Both IR loads see the same (pre-edge) MDR value.
        if (load_iru) begin
          iru_r <= mdr_r;
        end
        if (load_irl) begin
          irl_r <= mdr_r;
        end
      end
    end
  end

  assign opcode   = iru_r;
  assign operand  = irl_r;
  assign mdr      = mdr_r;
  assign pc       = pc_r;
  assign mem_addr = addr_s;

endmodule

// File: tb/tb_mem_fetch_unit.sv
module tb_mem_fetch_unit;

  logic       clk = 1'b0;
  logic       rst, load_pc, incr_pc, load_iru, load_irl, fetch, store_mem;
  logic [7:0] ac_in;
  logic       prog_en, prog_we;
  logic [7:0] prog_addr, prog_data;
  logic [7:0] opcode, operand, mdr, pc, mem_addr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] m_mem [256];
  logic [7:0] m_pc, m_iru, m_irl, m_mdr;
  logic [7:0] m_addr, m_rd;

  mem_fetch_unit #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .load_pc(load_pc), .incr_pc(incr_pc),
    .load_iru(load_iru), .load_irl(load_irl), .fetch(fetch),
    .store_mem(store_mem), .ac_in(ac_in), .prog_en(prog_en),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .opcode(opcode), .operand(operand), .mdr(mdr), .pc(pc),
    .mem_addr(mem_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: advance on each rising edge from the inputs held since the falling edge,
  // then compare every output shortly after the edge.
  always @(posedge clk) begin
    m_addr = prog_en ? prog_addr : (fetch ? m_pc : m_irl);
    m_rd   = m_mem[m_addr];
    if (rst) begin
      m_pc = 8'h00; m_iru = 8'h00; m_irl = 8'h00; m_mdr = 8'h00;
      if (prog_en && prog_we) m_mem[prog_addr] = prog_data;
    end else if (prog_en) begin
      if (prog_we) m_mem[prog_addr] = prog_data;
      m_mdr = m_rd;
    end else begin
      if (store_mem && !fetch) m_mem[m_irl] = ac_in;
      if (load_pc)      m_pc = m_irl;
      else if (incr_pc) m_pc = 8'((int'(m_pc) + 1) % 256);
      if (load_iru) m_iru = m_mdr;
      if (load_irl) m_irl = m_mdr;
      m_mdr = m_rd;
    end
    #1;
    chk("pc", pc, m_pc);
    chk("opcode", opcode, m_iru);
    chk("operand", operand, m_irl);
    chk("mdr", mdr, m_mdr);
    chk("mem_addr", mem_addr, prog_en ? prog_addr : (fetch ? m_pc : m_irl));
  end

  task automatic idle();
    rst = 1'b0; load_pc = 1'b0; incr_pc = 1'b0; load_iru = 1'b0; load_irl = 1'b0;
    fetch = 1'b1; store_mem = 1'b0; ac_in = 8'h00; prog_en = 1'b0; prog_we = 1'b0;
    prog_addr = 8'h00; prog_data = 8'h00;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [7:0] d, input logic r);
    idle(); rst = r; prog_en = 1'b1; prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
  endtask

  task automatic rand_strobes();
    load_pc = 1'($urandom); incr_pc = 1'($urandom); load_iru = 1'($urandom);
    load_irl = 1'($urandom); fetch = 1'($urandom); store_mem = 1'($urandom);
    ac_in = 8'($urandom);
  endtask

  initial begin
    idle(); rst = 1'b1;
    tick();
    // Preload whole RAM through the host port while held in reset.
    for (int i = 0; i < 256; i++) host_wr(8'(i), 8'($urandom), 1'b1);
    host_wr(8'h00, 8'h01, 1'b1);
    host_wr(8'h01, 8'h20, 1'b1);
    host_wr(8'h20, 8'h5A, 1'b1);
    host_wr(8'h10, 8'h80, 1'b1);
    host_wr(8'h80, 8'hFF, 1'b1);
    host_wr(8'hFF, 8'h99, 1'b1);

    // Fetch pair PREP_U / FETCH_U / PREP_L / FETCH_L
    idle(); tick();
    idle(); load_iru = 1'b1; incr_pc = 1'b1; tick();
    idle(); tick();
    idle(); load_irl = 1'b1; incr_pc = 1'b1; tick();
    chk("fetch_opcode", opcode, 8'h01);
    chk("fetch_operand", operand, 8'h20);
    chk("fetch_pc", pc, 8'h02);

    // Operand read, store collision, store with fetch=1
    idle(); fetch = 1'b0; tick();
    chk("operand_read", mdr, 8'h5A);
    idle(); fetch = 1'b0; store_mem = 1'b1; ac_in = 8'hC3; tick();
    chk("store_read_first", mdr, 8'h5A);
    idle(); fetch = 1'b0; tick();
    chk("store_visible", mdr, 8'hC3);
    idle(); fetch = 1'b1; store_mem = 1'b1; ac_in = 8'h11; tick();
    idle(); fetch = 1'b0; tick();
    chk("store_fetch1_nowrite", mdr, 8'hC3);

    // Reset with random strobes, RAM preserved
    for (int i = 0; i < 2; i++) begin idle(); rst = 1'b1; rand_strobes(); tick(); end
    chk("rst_pc", pc, 8'h00);
    chk("rst_opcode", opcode, 8'h00);
    chk("rst_operand", operand, 8'h00);
    chk("rst_mdr", mdr, 8'h00);
    idle(); prog_en = 1'b1; prog_addr = 8'h20; tick();
    chk("rst_ram_kept", mdr, 8'hC3);

    // Build PC=0x10, IRL=0x80, then jump beats increment
    host_wr(8'h00, 8'h10, 1'b0);
    idle(); fetch = 1'b0; tick();
    idle(); fetch = 1'b0; load_irl = 1'b1; tick();
    idle(); load_pc = 1'b1; tick();
    idle(); fetch = 1'b0; tick();
    idle(); fetch = 1'b0; load_irl = 1'b1; tick();
    chk("jump_pre_pc", pc, 8'h10);
    chk("jump_pre_irl", operand, 8'h80);
    idle(); load_pc = 1'b1; incr_pc = 1'b1; tick();
    chk("jump_priority", pc, 8'h80);

    // Wrap 0xFF -> 0x00 and fetch RAM[0]
    idle(); fetch = 1'b0; tick();
    idle(); fetch = 1'b0; load_irl = 1'b1; tick();
    idle(); load_pc = 1'b1; tick();
    chk("wrap_pre", pc, 8'hFF);
    idle(); incr_pc = 1'b1; tick();
    chk("wrap_pc", pc, 8'h00);
    idle(); tick();
    chk("wrap_fetch", mdr, 8'h10);

    // Host ownership freezes core
    for (int i = 0; i < 2; i++) begin
      idle(); prog_en = 1'b1; prog_addr = 8'h40; fetch = 1'b0;
      incr_pc = 1'b1; load_iru = 1'b1; store_mem = 1'b1; ac_in = 8'h55; tick();
    end
    chk("host_pc", pc, 8'h00);
    chk("host_iru", opcode, 8'h00);
    chk("host_irl", operand, 8'hFF);
    idle(); fetch = 1'b0; tick();
    chk("host_no_store", mdr, 8'h99);
    host_wr(8'h33, 8'h77, 1'b0);
    idle(); prog_en = 1'b1; prog_addr = 8'h33; tick();
    chk("host_readback", mdr, 8'h77);

    // Random phase, checked every cycle by the model process
    for (int i = 0; i < 3000; i++) begin
      idle(); rand_strobes();
      rst = ($urandom_range(0, 31) == 0);
      prog_en = ($urandom_range(0, 7) == 0);
      prog_we = 1'($urandom);
      prog_addr = 8'($urandom); prog_data = 8'($urandom);
      tick();
    end
    idle(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_fetch_unit.md
# mem_fetch_unit

Instruction-fetch and memory stage that sits directly downstream of the control unit. It contains the 256×8 unified program/data RAM, the program counter (PC), the upper and lower instruction registers (IRU/IRL) and the memory data register (MDR). It executes the control unit's strobes each cycle and returns the opcode the control unit decodes. A host program-load port writes RAM contents before or between runs.

## Interface
- `ADDR_W`, 8: address width; RAM depth is 2^ADDR_W; PC, IRL and addresses are ADDR_W bits.
- `DATA_W`, 8: data width of RAM, MDR, IRU, IRL and `ac_in`.
- `clk`  in  1: the single clock; every register updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high. Clears PC/IRU/IRL/MDR; does not clear RAM.
- `load_pc`  in  1: PC ← IRL (jump).
- `incr_pc`  in  1: PC ← PC+1.
- `load_iru`  in  1: IRU ← MDR.
- `load_irl`  in  1: IRL ← MDR.
- `fetch`  in  1: address select; 1 = PC, 0 = IRL (operand address).
- `store_mem`  in  1: write request; effective only when `fetch`=0.
- `ac_in`  in  DATA_W: accumulator value written on a store.
- `prog_en`  in  1: host owns RAM; core writes suppressed.
- `prog_we`  in  1: host write strobe (ignored unless `prog_en`).
- `prog_addr`  in  ADDR_W: host write/read address.
- `prog_data`  in  DATA_W: host write data.
- `opcode`  out  DATA_W: IRU contents, to control unit.
- `operand`  out  DATA_W: IRL contents, to datapath.
- `mdr`  out  DATA_W: registered RAM read data.
- `pc`  out  ADDR_W: current PC.
- `mem_addr`  out  ADDR_W: address presented to RAM this cycle.

## Operation
- Address mux (combinational):
  - `prog_en`=1 → `prog_addr`.
  - else `fetch`=1 → PC.
  - else IRL.
- MDR: on every clock edge, `MDR ← RAM[mem_addr]` (read-first). On a same-cycle write to the same address, MDR takes the old contents.
- Core write: when `store_mem` & ~`fetch` & ~`prog_en`, write `RAM[IRL] ← ac_in`. `store_mem` with `fetch`=1 performs no write.
- Host write: when `prog_en` & `prog_we`, write `RAM[prog_addr] ← prog_data`. Host writes are legal during `rst`.
- PC update, highest priority first:
  - `rst` → 0.
  - `load_pc` → IRL[ADDR_W-1:0].
  - `incr_pc` → PC+1, modulo 2^ADDR_W (0xFF → 0x00).
  - otherwise hold.
- PC, IRU and IRL freeze while `prog_en`=1. All core strobes are ignored.
- IRU/IRL: load from the current MDR value. `load_iru` and `load_irl` asserted together both load the same MDR value.
- `rst` mid-instruction: PC, IRU, IRL and MDR are 0 on the next edge. Any write in that same cycle is suppressed, except a host write.

## Timing
- Reset values: `pc`=0, `opcode`=0, `operand`=0, `mdr`=0. `mem_addr` follows the mux (0 after reset with `fetch`=1).
- Control inputs change on the falling edge. They are sampled on the next rising edge.
- Read latency is 1 cycle: the address presented in cycle N appears on `mdr` in cycle N+1. This is why the control unit holds a PREP state before each FETCH state.
- Write takes effect at the rising edge and is visible on `mdr` two cycles after the write cycle if the address is re-presented.
- Fetch pair: PREP_U(addr=PC) → FETCH_U (IRU←MDR, PC+1) → PREP_L → FETCH_L (IRL←MDR, PC+1). PC advances 2 per two-byte instruction.
- Operand read: EXECUTE_3A presents IRL. MDR holds the operand data in EXECUTE_3B.
- Single-byte class instructions advance PC by 1 only.

## Test plan
- Reset: drive `rst` for 2 cycles with random strobes → `pc`=0, `opcode`=0, `operand`=0, `mdr`=0; RAM contents preloaded via the program port are unchanged.
- Fetch: load RAM[0]=0x01 and RAM[1]=0x20 via the host port, then sequence PREP_U/FETCH_U/PREP_L/FETCH_L → `opcode`=0x01, `operand`=0x20, `pc`=2.
- Operand read then store:
  - With IRL=0x20 and RAM[0x20]=0x5A, drive `fetch`=0 for 1 cycle → `mdr`=0x5A.
  - Then `store_mem`=1 with `ac_in`=0xC3 → RAM[0x20]=0xC3, while `mdr` in that cycle still shows 0x5A.
  - `store_mem`=1 with `fetch`=1 → no RAM change.
- Jump priority: PC=0x10, IRL=0x80, `load_pc`=`incr_pc`=1 → `pc`=0x80.
- Wrap: PC=0xFF, `incr_pc` → `pc`=0x00, and the next fetch reads RAM[0x00].
- Host ownership: `prog_en`=1 with `incr_pc`, `load_iru` and `store_mem` pulsed → PC, IRU, IRL and RAM[IRL] unchanged. `prog_we` to 0x33=0x77 followed by a read of `prog_addr`=0x33 → `mdr`=0x77 one cycle later.
